bidirectional_spi_responder: RTL and testbench
==============================================

Name: bidirectional_spi_responder

Overview:
- Fabric-clocked 3-wire (half-duplex, shared SDIO) SPI peripheral. It is the far end of the bidirectional_spi initiator.
- It oversamples SCLK, CS_N and SDIO, then decodes frames of the form R/W bit, address, data.
- Write frames commit to an external register port. Read frames fetch from that port and drive SDIO back to the initiator.
- Used as a device model in benches and as a real responder for FPGA-to-FPGA control links.

Parameters:
- ADDR_WIDTH, 7, address bits per frame.
- DATA_WIDTH, 16, data bits per frame.
- SYNC_STAGES, 2, synchronizer depth on SCLK, CS_N and SDIO inputs (minimum 2).

Ports:
- fabric_clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- spi_cpol  in  1  clock polarity; must be static while spi_cs_n is low.
- spi_cpha  in  1  clock phase; must be static while spi_cs_n is low.
- spi_sclk  in  1  SPI clock from the initiator.
- spi_cs_n  in  1  chip select, active low.
- spi_sdio  inout  1  shared data line; driven only when the internal sdio_oe is 1, otherwise 'z'.
- reg_wr_en  out  1  single-cycle write strobe.
- reg_wr_addr  out  ADDR_WIDTH  write address.
- reg_wr_data  out  DATA_WIDTH  write data.
- reg_rd_en  out  1  single-cycle read request.
- reg_rd_addr  out  ADDR_WIDTH  read address.
- reg_rd_data  in  DATA_WIDTH  read data; valid exactly 1 cycle after reg_rd_en.
- frame_done  out  1  pulse: a complete frame was processed.
- frame_abort  out  1  pulse: CS_N rose before the frame completed.
- busy  out  1  high from CS_N fall until return to IDLE.

Behaviour:
- Reset values: all outputs 0, sdio_oe 0 (line released), state IDLE.
- Synchronization and edge detection:
  - SYNC_STAGES flops on each input, then one compare flop for edge detection.
  - An edge is detected SYNC_STAGES+1 cycles after the pin transition.
- Timing requirement: SCLK half-period ≥ 4 fabric_clk cycles. Faster SCLK is unsupported; behaviour is undefined.
- Edge roles:
  - Leading edge = SCLK leaving the CPOL level; trailing edge = return to it.
  - Sample edge = leading if CPHA=0, trailing if CPHA=1. Shift edge = the other one.
- Bit order: MSB first for address and data. Bit 0 of the frame is R/W (1 = write, 0 = read), matching the initiator's rw mask convention.
- FSM states:
  - IDLE: sdio_oe 0. On synchronized CS_N fall → CMD and clear the bit counter.
  - CMD: on sample edge, latch SDIO as rw → ADDR.
  - ADDR: on each sample edge, shift SDIO into the address register. After ADDR_WIDTH bits, go to WDATA if rw=1. If rw=0, pulse reg_rd_en with reg_rd_addr = address, then → RD_FETCH.
  - RD_FETCH: next cycle, load reg_rd_data into the shift register → RDATA.
  - RDATA: on each shift edge, set sdio_oe=1 and drive the shift MSB, then shift left.
    - First driven bit appears at the shift edge immediately after the last address sample (turnaround = half SCLK).
    - Also count sample edges (initiator sampling). After DATA_WIDTH of them, set sdio_oe=0 and go to DONE.
  - WDATA: on each sample edge, shift in SDIO. After DATA_WIDTH bits, pulse reg_wr_en with latched addr/data → DONE.
  - DONE: pulse frame_done once. Further SCLK edges are ignored and SDIO stays released. Wait for CS_N rise → IDLE.
- CS_N rise in CMD, ADDR, WDATA, RD_FETCH or RDATA:
  - Same cycle: sdio_oe=0 and frame_abort pulse; no reg_wr_en.
  - Next cycle: → IDLE.
  - A reg_rd_en already issued is not retracted.
- CS_N fall while not IDLE: impossible without a prior rise; a rise always takes priority.
- Sample and CS_N edge detected in the same cycle: the CS_N rise wins and the bit is discarded.
- Counter widths: $clog2(max(ADDR_WIDTH, DATA_WIDTH)+1). Counters never wrap, because the FSM leaves the state at the terminal count.
- Asynchronous reset mid-frame: line released immediately, no strobes. After reset, the FSM waits for a fresh CS_N fall; it ignores a CS_N that is already low.

Decomposition:
- Package bidirectional_spi_pkg holds:
  - the responder state enum (IDLE, CMD, ADDR, WDATA, RD_FETCH, RDATA, DONE);
  - the RW_WRITE=1 / RW_READ=0 constants.
- Sub-module spi_input_sync: SYNC_STAGES synchronizer plus rise/fall pulse outputs. Instantiated three times (SDIO uses the level only).

Test Plan:
1. Mode 0, write addr 0x15, data 0xBEEF, SCLK = fabric/8 → exactly one reg_wr_en with addr 0x15, data 0xBEEF; one frame_done; sdio_oe never 1.
2. Mode 3, read addr 0x2A, reg_rd_data=0xA5C3 → one reg_rd_en with addr 0x2A; initiator captures 0xA5C3; SDIO is 'z' before the turnaround and after the 16th bit.
3. Modes 1 and 2, back-to-back write 0x01/0x1234 then read 0x01 (external reg model) → read returns 0x1234; two frame_done; no frame_abort.
4. Write frame, CS_N raised after 10 data bits → frame_abort=1 for one cycle; no reg_wr_en; next full frame (write 0x7F/0x0001) commits correctly.
5. Write 0x03/0x00FF followed by 5 extra SCLK cycles before CS_N rise → single reg_wr_en; extra clocks ignored; SDIO stays released.
6. reset_n asserted during RDATA bit 6 → sdio_oe=0 asynchronously; after release with CS_N still low, no frame is decoded until CS_N rises and falls again.

Source files
------------

// File: rtl/bidirectional_spi_pkg.sv
// Shared types and constants for the 3-wire SPI responder.
// Frame order on the wire: R/W bit, then address MSB first, then data MSB first.
package bidirectional_spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        WDATA,
        RD_FETCH,
        RDATA,
        DONE
    } resp_state_t;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bidirectional_spi_responder_sync.sv
// Multi-flop synchronizer with one compare flop for rise/fall pulse detection.
// Resets low, so a chip select that is already low after reset never reads as a fall.
module spi_input_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic fabric_clk,
    input  logic reset_n,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain_reg;
    logic                   prev_reg;

    always_ff @(posedge fabric_clk or negedge reset_n) begin
        if (!reset_n) begin
            chain_reg <= '0;
            prev_reg  <= 1'b0;
        end else begin
            chain_reg <= {chain_reg[SYNC_STAGES-2:0], pin};
            prev_reg  <= chain_reg[SYNC_STAGES-1];
        end
    end

    assign level = chain_reg[SYNC_STAGES-1];
    assign rise  = level & ~prev_reg;
    assign fall  = ~level & prev_reg;

endmodule

// File: rtl/bidirectional_spi_responder.sv
// 3-wire SPI responder: decodes R/W + address + data frames from an oversampled
// SPI bus, commits writes to a register port and answers reads on the shared SDIO.
module bidirectional_spi_responder
    import bidirectional_spi_pkg::*;
#(
    parameter int ADDR_WIDTH  = 7,
    parameter int DATA_WIDTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  fabric_clk,
    input  logic                  reset_n,
    input  logic                  spi_cpol,
    input  logic                  spi_cpha,
    input  logic                  spi_sclk,
    input  logic                  spi_cs_n,
    inout  wire                   spi_sdio,
    output logic                  reg_wr_en,
    output logic [ADDR_WIDTH-1:0] reg_wr_addr,
    output logic [DATA_WIDTH-1:0] reg_wr_data,
    output logic                  reg_rd_en,
    output logic [ADDR_WIDTH-1:0] reg_rd_addr,
    input  logic [DATA_WIDTH-1:0] reg_rd_data,
    output logic                  frame_done,
    output logic                  frame_abort,
    output logic                  busy
);

    localparam int CNT_W = $clog2(max_int(ADDR_WIDTH, DATA_WIDTH) + 1);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);

    // Index 0 = SCLK, 1 = CS_N, 2 = SDIO
    logic [2:0] pin_vec;
    logic [2:0] level_vec;
    logic [2:0] rise_vec;
    logic [2:0] fall_vec;

    assign pin_vec = {spi_sdio, spi_cs_n, spi_sclk};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            spi_input_sync #(
                .SYNC_STAGES(SYNC_STAGES)
            ) u_sync (
                .fabric_clk(fabric_clk),
                .reset_n   (reset_n),
                .pin       (pin_vec[gi]),
                .level     (level_vec[gi]),
                .rise      (rise_vec[gi]),
                .fall      (fall_vec[gi])
            );
        end
    endgenerate

    logic sync_unused;
    assign sync_unused = ^{level_vec[1:0], rise_vec[2], fall_vec[2]};

    logic sdio_level;
    logic cs_rise;
    logic cs_fall;
    logic lead_edge;
    logic trail_edge;
    logic sample_edge;
    logic shift_edge;

    assign sdio_level  = level_vec[2];
    assign cs_rise     = rise_vec[1];
    assign cs_fall     = fall_vec[1];
    // Leading edge leaves the CPOL idle level; CPHA picks which edge samples.
    assign lead_edge   = spi_cpol ? fall_vec[0] : rise_vec[0];
    assign trail_edge  = spi_cpol ? rise_vec[0] : fall_vec[0];
    assign sample_edge = spi_cpha ? trail_edge : lead_edge;
    assign shift_edge  = spi_cpha ? lead_edge : trail_edge;

    resp_state_t             state_reg;
    logic [CNT_W-1:0]        bit_cnt_reg;
    logic                    rw_reg;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [DATA_WIDTH-1:0]   shift_reg;
    logic                    sdio_oe_reg;
    logic                    sdio_out_reg;
    logic                    wr_en_reg;
    logic [ADDR_WIDTH-1:0]   wr_addr_reg;
    logic [DATA_WIDTH-1:0]   wr_data_reg;
    logic                    rd_en_reg;
    logic [ADDR_WIDTH-1:0]   rd_addr_reg;
    logic                    done_reg;
    logic                    abort_reg;
    logic                    busy_reg;

    logic [ADDR_WIDTH-1:0]   addr_next;
    logic [DATA_WIDTH-1:0]   data_next;

    assign addr_next = {addr_reg[ADDR_WIDTH-2:0], sdio_level};
    assign data_next = {shift_reg[DATA_WIDTH-2:0], sdio_level};

    always_ff @(posedge fabric_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            bit_cnt_reg  <= '0;
            rw_reg       <= RW_READ;
            addr_reg     <= '0;
            shift_reg    <= '0;
            sdio_oe_reg  <= 1'b0;
            sdio_out_reg <= 1'b0;
            wr_en_reg    <= 1'b0;
            wr_addr_reg  <= '0;
            wr_data_reg  <= '0;
            rd_en_reg    <= 1'b0;
            rd_addr_reg  <= '0;
            done_reg     <= 1'b0;
            abort_reg    <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            wr_en_reg <= 1'b0;
            rd_en_reg <= 1'b0;
            done_reg  <= 1'b0;
            abort_reg <= 1'b0;

            // A CS_N rise mid-frame outranks any SCLK edge seen in the same cycle.
            if (cs_rise && state_reg != IDLE && state_reg != DONE) begin
                sdio_oe_reg <= 1'b0;
                abort_reg   <= 1'b1;
                busy_reg    <= 1'b0;
                state_reg   <= IDLE;
            end else begin
                case (state_reg)
                    IDLE: begin
                        sdio_oe_reg <= 1'b0;
                        if (cs_fall) begin
                            bit_cnt_reg <= '0;
                            busy_reg    <= 1'b1;
                            state_reg   <= CMD;
                        end
                    end
                    CMD: begin
                        if (sample_edge) begin
                            rw_reg      <= sdio_level;
                            bit_cnt_reg <= '0;
                            state_reg   <= ADDR;
                        end
                    end
                    ADDR: begin
                        if (sample_edge) begin
                            addr_reg <= addr_next;
                            if (bit_cnt_reg == ADDR_LAST) begin
                                bit_cnt_reg <= '0;
                                if (rw_reg == RW_WRITE) begin
                                    state_reg <= WDATA;
                                end else begin
                                    rd_en_reg   <= 1'b1;
                                    rd_addr_reg <= addr_next;
                                    state_reg   <= RD_FETCH;
                                end
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + 1'b1;
                            end
                        end
                    end
                    RD_FETCH: begin
                        // First cycle carries the request; read data is valid on the second.
                        if (bit_cnt_reg == '0) begin
                            bit_cnt_reg <= CNT_W'(1);
                        end else begin
                            shift_reg   <= reg_rd_data;
                            bit_cnt_reg <= '0;
                            state_reg   <= RDATA;
                        end
                    end
                    RDATA: begin
                        if (shift_edge) begin
                            sdio_oe_reg  <= 1'b1;
                            sdio_out_reg <= shift_reg[DATA_WIDTH-1];
                            shift_reg    <= {shift_reg[DATA_WIDTH-2:0], 1'b0};
                        end
                        if (sample_edge) begin
                            if (bit_cnt_reg == DATA_LAST) begin
                                sdio_oe_reg <= 1'b0;
                                done_reg    <= 1'b1;
                                bit_cnt_reg <= '0;
                                state_reg   <= DONE;
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + 1'b1;
                            end
                        end
                    end
                    WDATA: begin
                        if (sample_edge) begin
                            shift_reg <= data_next;
                            if (bit_cnt_reg == DATA_LAST) begin
                                wr_en_reg   <= 1'b1;
                                wr_addr_reg <= addr_reg;
                                wr_data_reg <= data_next;
                                done_reg    <= 1'b1;
                                bit_cnt_reg <= '0;
                                state_reg   <= DONE;
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        sdio_oe_reg <= 1'b0;
                        if (cs_rise) begin
                            busy_reg  <= 1'b0;
                            state_reg <= IDLE;
                        end
                    end
                    default: begin
                        sdio_oe_reg <= 1'b0;
                        busy_reg    <= 1'b0;
                        state_reg   <= IDLE;
                    end
                endcase
            end
        end
    end

    assign spi_sdio    = sdio_oe_reg ? sdio_out_reg : 1'bz;
    assign reg_wr_en   = wr_en_reg;
    assign reg_wr_addr = wr_addr_reg;
    assign reg_wr_data = wr_data_reg;
    assign reg_rd_en   = rd_en_reg;
    assign reg_rd_addr = rd_addr_reg;
    assign frame_done  = done_reg;
    assign frame_abort = abort_reg;
    assign busy        = busy_reg;

endmodule

// File: tb/tb_bidirectional_spi_responder.sv
// Directed plus randomized frames from a behavioural SPI initiator, checked
// against a frame-level register model; the SDIO line is pulled up when released.
module tb_bidirectional_spi_responder;

    logic        fabric_clk = 1'b0;
    logic        reset_n    = 1'b0;
    logic        spi_cpol   = 1'b0;
    logic        spi_cpha   = 1'b0;
    logic        spi_sclk   = 1'b0;
    logic        spi_cs_n   = 1'b1;
    logic        tb_oe      = 1'b0;
    logic        tb_out     = 1'b0;
    wire         spi_sdio;
    logic        reg_wr_en;
    logic [6:0]  reg_wr_addr;
    logic [15:0] reg_wr_data;
    logic        reg_rd_en;
    logic [6:0]  reg_rd_addr;
    logic [15:0] reg_rd_data;
    logic        frame_done;
    logic        frame_abort;
    logic        busy;

    pullup (spi_sdio);
    assign spi_sdio = tb_oe ? tb_out : 1'bz;

    always #5 fabric_clk = ~fabric_clk;

    bidirectional_spi_responder #(
        .ADDR_WIDTH (7),
        .DATA_WIDTH (16),
        .SYNC_STAGES(2)
    ) dut (
        .fabric_clk (fabric_clk),
        .reset_n    (reset_n),
        .spi_cpol   (spi_cpol),
        .spi_cpha   (spi_cpha),
        .spi_sclk   (spi_sclk),
        .spi_cs_n   (spi_cs_n),
        .spi_sdio   (spi_sdio),
        .reg_wr_en  (reg_wr_en),
        .reg_wr_addr(reg_wr_addr),
        .reg_wr_data(reg_wr_data),
        .reg_rd_en  (reg_rd_en),
        .reg_rd_addr(reg_rd_addr),
        .reg_rd_data(reg_rd_data),
        .frame_done (frame_done),
        .frame_abort(frame_abort),
        .busy       (busy)
    );

    // Power-on contents of the external register file.
    function automatic logic [15:0] init_val(input logic [6:0] a);
        return (a == 7'h2A) ? 16'hA5C3 : {1'b0, a, ~a, 1'b0};
    endfunction

    // External register port: registered read, strobe counters.
    logic        hclr = 1'b1;
    logic [15:0] dev_mem [128];
    logic        dev_written [128];
    int          wr_cnt;
    int          rd_cnt;
    int          done_cnt;
    int          abort_cnt;
    logic [6:0]  last_wr_addr;
    logic [15:0] last_wr_data;
    logic [6:0]  last_rd_addr;

    always @(posedge fabric_clk) begin
        if (hclr) begin
            for (int k = 0; k < 128; k++) dev_written[k] <= 1'b0;
            wr_cnt       <= 0;
            rd_cnt       <= 0;
            done_cnt     <= 0;
            abort_cnt    <= 0;
            reg_rd_data  <= '0;
            last_wr_addr <= '0;
            last_wr_data <= '0;
            last_rd_addr <= '0;
        end else begin
            if (reg_wr_en) begin
                dev_mem[reg_wr_addr]     <= reg_wr_data;
                dev_written[reg_wr_addr] <= 1'b1;
                wr_cnt                   <= wr_cnt + 1;
                last_wr_addr             <= reg_wr_addr;
                last_wr_data             <= reg_wr_data;
            end
            if (reg_rd_en) begin
                reg_rd_data  <= dev_written[reg_rd_addr] ? dev_mem[reg_rd_addr]
                                                         : init_val(reg_rd_addr);
                rd_cnt       <= rd_cnt + 1;
                last_rd_addr <= reg_rd_addr;
            end
            if (frame_done)  done_cnt  <= done_cnt + 1;
            if (frame_abort) abort_cnt <= abort_cnt + 1;
        end
    end

    logic [15:0] model_mem [128];
    int          total = 0;
    int          bad   = 0;
    int          hp    = 4;
    int          n_frames = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge fabric_clk);
        #1;
    endtask

    task automatic set_mode(input logic pol, input logic pha);
        spi_cpol = pol;
        spi_cpha = pha;
        spi_sclk = pol;
        wait_cyc(6);
    endtask

    // Initiator shift step for frame bit j; releases the line at the read turnaround.
    task automatic shift_step(input logic rw, input logic [23:0] fr, input int j);
        if (j < 24 && (rw == 1'b1 || j < 8)) begin
            tb_oe  = 1'b1;
            tb_out = fr[23-j];
        end else begin
            tb_oe = 1'b0;
        end
        if (rw == 1'b0 && j == 8) begin
            wait_cyc(1);
            chk("turnaround_released", {31'd0, spi_sdio}, 32'd1);
            wait_cyc(hp - 1);
        end else begin
            wait_cyc(hp);
        end
    endtask

    task automatic spi_bits(input logic rw, input logic [6:0] a, input logic [15:0] d,
                            input int nbits, input int rst_at, output logic [15:0] rdata);
        logic [23:0] fr;
        fr    = {rw, a, d};
        rdata = '0;
        if (!spi_cpha) shift_step(rw, fr, 0);
        for (int i = 0; i < nbits; i++) begin
            if (spi_cpha) begin
                spi_sclk = ~spi_cpol;
                shift_step(rw, fr, i);
            end
            if (i == rst_at) begin
                chk("rst_pre_driven_bit", {31'd0, spi_sdio}, 32'd0);
                reset_n = 1'b0;
                #1;
                chk("rst_line_released", {31'd0, spi_sdio}, 32'd1);
                chk("rst_outputs_zero", {27'd0, busy, frame_done, frame_abort, reg_wr_en, reg_rd_en}, 32'd0);
                wait_cyc(2);
                reset_n = 1'b1;
            end
            if (i >= 8) rdata = {rdata[14:0], spi_sdio};
            spi_sclk = spi_cpha ? spi_cpol : ~spi_cpol;
            wait_cyc(hp);
            if (!spi_cpha) begin
                spi_sclk = spi_cpol;
                shift_step(rw, fr, i + 1);
            end
        end
        tb_oe = 1'b0;
    endtask

    // One complete frame, checked against the register model.
    task automatic xfer(input logic rw, input logic [6:0] a, input logic [15:0] d, input int extra);
        int          wr0, rd0, dn0, ab0;
        logic [15:0] rdat;
        wr0 = wr_cnt; rd0 = rd_cnt; dn0 = done_cnt; ab0 = abort_cnt;
        spi_cs_n = 1'b0;
        wait_cyc(hp);
        chk("busy_after_cs_fall", {31'd0, busy}, 32'd1);
        spi_bits(rw, a, d, 24, -1, rdat);
        for (int k = 0; k < extra; k++) begin
            spi_sclk = ~spi_cpol;
            wait_cyc(hp);
            spi_sclk = spi_cpol;
            wait_cyc(hp);
        end
        wait_cyc(hp);
        chk("released_after_frame", {31'd0, spi_sdio}, 32'd1);
        spi_cs_n = 1'b1;
        wait_cyc(8);
        chk("frame_done_count", done_cnt - dn0, 1);
        chk("frame_abort_count", abort_cnt - ab0, 0);
        chk("busy_after_cs_rise", {31'd0, busy}, 32'd0);
        if (rw) begin
            chk("wr_strobe_count", wr_cnt - wr0, 1);
            chk("rd_strobe_count", rd_cnt - rd0, 0);
            chk("wr_addr", {25'd0, last_wr_addr}, {25'd0, a});
            chk("wr_data", {16'd0, last_wr_data}, {16'd0, d});
            model_mem[a] = d;
        end else begin
            chk("rd_strobe_count", rd_cnt - rd0, 1);
            chk("wr_strobe_count", wr_cnt - wr0, 0);
            chk("rd_addr", {25'd0, last_rd_addr}, {25'd0, a});
            chk("rd_data", {16'd0, rdat}, {16'd0, model_mem[a]});
        end
        n_frames++;
        $display("frame %0d mode=%0d %s addr=%02h data=%04h hp=%0d",
                 n_frames, {spi_cpol, spi_cpha}, rw ? "WR" : "RD", a,
                 rw ? d : rdat, hp);
    endtask

    initial begin
        logic [15:0] rdat;
        int          wr0, rd0, dn0, ab0;
        logic        rw;
        logic [6:0]  a;
        logic [15:0] d;

        for (int k = 0; k < 128; k++) model_mem[k] = init_val(7'(k));

        // Reset state
        wait_cyc(3);
        chk("reset_outputs", {busy, frame_done, frame_abort, reg_wr_en, reg_rd_en,
                              reg_wr_addr, reg_rd_addr}, 32'd0);
        chk("reset_wr_data", {16'd0, reg_wr_data}, 32'd0);
        chk("reset_line_released", {31'd0, spi_sdio}, 32'd1);
        reset_n = 1'b1;
        hclr    = 1'b0;
        wait_cyc(4);

        // Mode 0 write
        set_mode(1'b0, 1'b0);
        xfer(1'b1, 7'h15, 16'hBEEF, 0);

        // Mode 3 read of a preset register
        set_mode(1'b1, 1'b1);
        xfer(1'b0, 7'h2A, 16'h0000, 0);

        // Modes 1 and 2: write then read back
        set_mode(1'b0, 1'b1);
        xfer(1'b1, 7'h01, 16'h1234, 0);
        xfer(1'b0, 7'h01, 16'h0000, 0);
        set_mode(1'b1, 1'b0);
        xfer(1'b1, 7'h01, 16'h1234, 0);
        xfer(1'b0, 7'h01, 16'h0000, 0);

        // Abort after 10 data bits, then a clean frame
        set_mode(1'b0, 1'b0);
        wr0 = wr_cnt; dn0 = done_cnt; ab0 = abort_cnt;
        spi_cs_n = 1'b0;
        wait_cyc(hp);
        spi_bits(1'b1, 7'h22, 16'h5555, 18, -1, rdat);
        spi_cs_n = 1'b1;
        wait_cyc(8);
        chk("abort_count", abort_cnt - ab0, 1);
        chk("abort_no_write", wr_cnt - wr0, 0);
        chk("abort_no_done", done_cnt - dn0, 0);
        chk("abort_busy_clear", {31'd0, busy}, 32'd0);
        $display("frame abort mode=0 WR addr=22 after 10 data bits");
        xfer(1'b1, 7'h7F, 16'h0001, 0);
        xfer(1'b0, 7'h22, 16'h0000, 0);

        // Extra SCLK cycles after a complete write
        xfer(1'b1, 7'h03, 16'h00FF, 5);

        // Reset during read data bit 6, CS_N held low throughout
        wr0 = wr_cnt; rd0 = rd_cnt; dn0 = done_cnt; ab0 = abort_cnt;
        spi_cs_n = 1'b0;
        wait_cyc(hp);
        spi_bits(1'b0, 7'h44, 16'h0000, 24, 14, rdat);
        wait_cyc(hp);
        spi_bits(1'b1, 7'h10, 16'hFFFF, 24, -1, rdat);
        wait_cyc(hp);
        chk("rst_rd_issued_once", rd_cnt - rd0, 1);
        chk("rst_no_write", wr_cnt - wr0, 0);
        chk("rst_no_done", done_cnt - dn0, 0);
        chk("rst_idle_busy", {31'd0, busy}, 32'd0);
        spi_cs_n = 1'b1;
        wait_cyc(8);
        chk("rst_no_abort", abort_cnt - ab0, 0);
        $display("frame reset mid-read addr=44, ignored frame with CS_N held low");
        xfer(1'b1, 7'h10, 16'hFFFF, 0);
        xfer(1'b0, 7'h10, 16'h0000, 0);

        // Randomized frames in random modes and SCLK rates
        for (int n = 0; n < 12; n++) begin
            set_mode(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            hp = $urandom_range(4, 6);
            rw = 1'($urandom_range(0, 1));
            a  = 7'($urandom_range(0, 127));
            d  = 16'($urandom);
            xfer(rw, a, d, $urandom_range(0, 2));
            if (rw) xfer(1'b0, a, 16'h0000, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
